pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
Parametrised multi-channel pattern player, successor to the single-channel free-running blinker. It latches a packed bit pattern per channel through a valid/ready load handshake. Each channel's pattern is replayed LSB-first on one LED output, advancing one bit every TICK_RATE clocks, in one-shot or loop mode with a runtime length. It sits between message-source logic (Morse encoders, status generators) and board pins.

Parameters:
TICK_RATE, 5_000_000, clocks per pattern bit (>=1; 1 = one bit per clock)
MESSAGE_WIDTH, 128, maximum pattern length in bits per channel (>=2)
CHANNELS, 1, number of independent LED channels sharing one bit index (>=1)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
pattern  in  CHANNELS*MESSAGE_WIDTH  packed patterns; channel c occupies bits [c*MESSAGE_WIDTH +: MESSAGE_WIDTH]
length  in  $clog2(MESSAGE_WIDTH+1)  bits to play per pass
loop  in  1  1 = repeat forever, 0 = one-shot
load_valid  in  1  request to latch pattern/length/loop
load_ready  out  1  high only in IDLE
abort  in  1  stop playback
LED  out  CHANNELS  current pattern bit per channel
START  out  1  high while bit index 0 is displayed in PLAY
DONE  out  1  one-cycle pulse on one-shot completion
BUSY  out  1  high in PLAY
blink_index  out  $clog2(MESSAGE_WIDTH)  current bit index

Behaviour:
- States: IDLE, PLAY. Tick counter width max(1,$clog2(TICK_RATE)).
- Reset (RST=1 at a clock edge; overrides every other input, including mid-playback):
  - state IDLE; blink_index=0; tick=0
  - pattern, length and loop registers cleared
  - LED=0, START=0, DONE=0, BUSY=0, load_ready=1 from the following cycle
- IDLE:
  - LED=0, START=0, BUSY=0, load_ready=1.
  - Handshake fires when load_valid && load_ready at an edge.
  - On that edge: latch pattern and loop; latch effective length (length==0 or length>MESSAGE_WIDTH -> MESSAGE_WIDTH); set index=0, tick=0; go to PLAY.
  - abort in IDLE has no effect; a load in the same cycle is still accepted.
- PLAY:
  - LED[c] = latched pattern bit [c*MESSAGE_WIDTH + blink_index].
  - LED is combinational from registers, with no extra pipeline stage.
  - tick increments every clock. When tick==TICK_RATE-1: tick<=0 and the bit ends.
    - If index < len-1: index+1.
    - Else if loop=1: index<=0 (wrap, no DONE).
    - Else: go to IDLE, index<=0, DONE=1 for exactly the next cycle.
  - Each bit is displayed exactly TICK_RATE cycles, including bit 0 after a wrap.
  - Effective length 1: the same bit is shown; START stays high throughout; a one-shot ends after TICK_RATE cycles.
- abort in PLAY: next cycle IDLE, index=0, tick=0, DONE stays 0. abort has priority over a simultaneous bit end or completion.
- load_valid in PLAY is ignored (load_ready=0); inputs are not re-sampled during playback.
- Latency:
  - Load accepted on edge N -> bit 0 shown on cycles N+1..N+TICK_RATE.
  - One-shot with effective length L: BUSY high for L*TICK_RATE cycles.
  - DONE and load_ready are both high in the first IDLE cycle, so a back-to-back load is possible with zero gap cycles in IDLE.
- DONE, BUSY and START are mutually consistent: DONE=1 implies BUSY=0; START=1 implies BUSY=1.

Test Plan:
(TICK_RATE=4, MESSAGE_WIDTH=8, CHANNELS=2 unless noted)
1. Reset, then load ch0=8'b1011_0010, ch1=8'hFF, length=8, loop=0 -> LED[0] reads 0,1,0,0,1,1,0,1 with each value held 4 cycles; LED[1]=1 throughout. BUSY high 32 cycles, then one DONE pulse; START high only the first 4 cycles.
2. length=3, loop=1, ch0=8'b0000_0101 -> LED[0] repeats 1,0,1 every 12 cycles for >=3 passes. START high 4 cycles per pass, DONE never asserts.
3. length=0 and length=15 (clamp) -> both play 8 bits (32 cycles BUSY); blink_index never exceeds 7.
4. Assert abort at cycle 10 of playback, together with load_valid=1 -> IDLE next cycle, LED=0, DONE=0, load_ready=1. load_valid held high -> new load accepted that same cycle.
5. Hold load_valid high through a one-shot -> second load accepted in the DONE cycle; bit 0 of the new pattern appears the next cycle (no gap).
6. Assert RST mid-pattern at index 5 with loop=1 -> all outputs 0 next cycle, load_ready=1, no DONE. Rerun case 1 with TICK_RATE=1 -> one bit per clock, BUSY high 8 cycles.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Multi-channel LED pattern player: latches per-channel bit patterns through a
// valid/ready load and replays them LSB-first, one bit every TICK_RATE clocks.
module pattern_sequencer #(
    parameter int TICK_RATE     = 5_000_000,
    parameter int MESSAGE_WIDTH = 128,
    parameter int CHANNELS      = 1
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [CHANNELS*MESSAGE_WIDTH-1:0]     pattern,
    input  logic [$clog2(MESSAGE_WIDTH+1)-1:0]    length,
    input  logic                                  loop,
    input  logic                                  load_valid,
    output logic                                  load_ready,
    input  logic                                  abort,
    output logic [CHANNELS-1:0]                   LED,
    output logic                                  START,
    output logic                                  DONE,
    output logic                                  BUSY,
    output logic [$clog2(MESSAGE_WIDTH)-1:0]      blink_index
);

    localparam int LW = $clog2(MESSAGE_WIDTH + 1);
    localparam int IW = $clog2(MESSAGE_WIDTH);
    localparam int TW = (TICK_RATE > 1) ? $clog2(TICK_RATE) : 1;
    localparam int PW = CHANNELS * MESSAGE_WIDTH;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_RATE - 1);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MESSAGE_WIDTH);

    typedef enum logic {
        IDLE,
        PLAY
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [PW-1:0]   pat_q, pat_d;
    logic [LW-1:0]   len_q, len_d;
    logic            loop_q, loop_d;
    logic            done_q, done_d;

    logic            busy;
    logic            tick_last;
    logic            last_bit;
    logic [LW-1:0]   len_eff;

    assign busy      = (state_q == PLAY);
    assign tick_last = (tick_q == TICK_LAST);
    assign last_bit  = (LW'(idx_q) == len_q - LW'(1));

    // Zero or over-range lengths play the full message width.
    assign len_eff = ((length == '0) || (length > LEN_MAX)) ? LEN_MAX : length;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        pat_d   = pat_q;
        len_d   = len_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    pat_d   = pattern;
                    len_d   = len_eff;
                    loop_d  = loop;
                    idx_d   = '0;
                    tick_d  = '0;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    tick_d  = '0;
                end else if (tick_last) begin
                    tick_d = '0;
                    if (!last_bit) begin
                        idx_d = idx_q + IW'(1);
                    end else if (loop_q) begin
                        idx_d = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tick_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_led
        logic [MESSAGE_WIDTH-1:0] ch_pat;
        assign ch_pat = pat_q[c*MESSAGE_WIDTH +: MESSAGE_WIDTH];
        assign LED[c] = busy && ch_pat[idx_q];
    end

    assign load_ready  = !busy;
    assign BUSY        = busy;
    assign START       = busy && (idx_q == '0);
    assign DONE        = done_q;
    assign blink_index = idx_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Randomized and directed bench for pattern_sequencer; two instances
// (TICK_RATE 4 and 1) share stimulus and are checked against a timing model.
module tb_pattern_sequencer;

    localparam int MW = 8;
    localparam int CH = 2;
    localparam int LW = $clog2(MW + 1);
    localparam int IW = $clog2(MW);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [CH*MW-1:0]  pattern;
    logic [LW-1:0]     length;
    logic              loop_i;
    logic              load_valid;
    logic              abort;

    logic [CH-1:0]     led   [2];
    logic              start [2];
    logic              done  [2];
    logic              busy  [2];
    logic              ready [2];
    logic [IW-1:0]     bidx  [2];

    pattern_sequencer #(
        .TICK_RATE(4), .MESSAGE_WIDTH(MW), .CHANNELS(CH)
    ) u_dut4 (
        .CLK(clk), .RST(rst), .pattern(pattern), .length(length),
        .loop(loop_i), .load_valid(load_valid), .load_ready(ready[0]),
        .abort(abort), .LED(led[0]), .START(start[0]), .DONE(done[0]),
        .BUSY(busy[0]), .blink_index(bidx[0])
    );

    pattern_sequencer #(
        .TICK_RATE(1), .MESSAGE_WIDTH(MW), .CHANNELS(CH)
    ) u_dut1 (
        .CLK(clk), .RST(rst), .pattern(pattern), .length(length),
        .loop(loop_i), .load_valid(load_valid), .load_ready(ready[1]),
        .abort(abort), .LED(led[1]), .START(start[1]), .DONE(done[1]),
        .BUSY(busy[1]), .blink_index(bidx[1])
    );

    // Model: elapsed cycles since the load edge determine everything shown.
    bit               m_play [2];
    bit               m_done [2];
    int               m_n    [2];
    int               m_len  [2];
    bit               m_loop [2];
    logic [CH*MW-1:0] m_pat  [2];

    int total = 0;
    int bad   = 0;

    function automatic int tr_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        int ei;
        logic [CH-1:0] el;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_play[d] = 1'b0;
                m_done[d] = 1'b0;
                m_n[d]    = 0;
            end else if (!m_play[d]) begin
                m_done[d] = 1'b0;
                if (load_valid) begin
                    m_play[d] = 1'b1;
                    m_n[d]    = 0;
                    m_pat[d]  = pattern;
                    m_loop[d] = loop_i;
                    m_len[d]  = (length == 0 || int'(length) > MW)
                                ? MW : int'(length);
                end
            end else begin
                m_done[d] = 1'b0;
                if (abort) begin
                    m_play[d] = 1'b0;
                end else begin
                    m_n[d]++;
                    if (!m_loop[d] && m_n[d] >= m_len[d] * tr_of(d)) begin
                        m_play[d] = 1'b0;
                        m_done[d] = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            ei = m_play[d] ? (m_n[d] / tr_of(d)) % m_len[d] : 0;
            for (int c = 0; c < CH; c++)
                el[c] = m_play[d] && m_pat[d][c*MW + ei];
            check_eq($sformatf("d%0d.led", d), 32'(led[d]), 32'(el));
            check_eq($sformatf("d%0d.busy", d), 32'(busy[d]), 32'(m_play[d]));
            check_eq($sformatf("d%0d.ready", d), 32'(ready[d]), 32'(!m_play[d]));
            check_eq($sformatf("d%0d.done", d), 32'(done[d]), 32'(m_done[d]));
            check_eq($sformatf("d%0d.start", d), 32'(start[d]),
                     32'(m_play[d] && ei == 0));
            check_eq($sformatf("d%0d.idx", d), 32'(bidx[d]), 32'(ei));
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic load(input logic [CH*MW-1:0] p, input logic [LW-1:0] l,
                        input logic lp);
        pattern    = p;
        length     = l;
        loop_i     = lp;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        abort      = 1'b0;
        pattern    = '0;
        length     = '0;
        loop_i     = 1'b0;
        @(negedge clk);
        run(2);
        rst = 1'b0;
        run(1);

        load(16'hFF_B2, 4'd8, 1'b0);
        run(40);

        load(16'hA5_05, 4'd3, 1'b1);
        run(40);
        abort = 1'b1;
        step();
        abort = 1'b0;
        run(2);

        load(16'h5A_C3, 4'd0, 1'b0);
        run(36);
        load(16'h12_E7, 4'd15, 1'b0);
        run(36);

        load(16'h3C_5A, 4'd8, 1'b0);
        run(9);
        abort      = 1'b1;
        load_valid = 1'b1;
        pattern    = 16'h81_7E;
        step();
        abort = 1'b0;
        run(3);
        load_valid = 1'b0;
        run(40);

        pattern    = 16'h0F_29;
        length     = 4'd5;
        loop_i     = 1'b0;
        load_valid = 1'b1;
        run(50);
        load_valid = 1'b0;
        run(10);

        load(16'h66_99, 4'd8, 1'b1);
        run(21);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(3);

        load(16'hFF_B2, 4'd8, 1'b0);
        run(12);

        repeat (400) begin
            rst        = ($urandom % 100) == 0;
            load_valid = ($urandom % 4) == 0;
            abort      = ($urandom % 20) == 0;
            pattern    = CH*MW'($urandom);
            length     = LW'($urandom % 16);
            loop_i     = ($urandom % 3) == 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
